aff7seg_mux: RTL and testbench

AFF7SEG_MUX -- requirements
Module: aff7seg_mux

---
 rtl/aff7seg_mux.sv | 161 ++++++++++++++++
 tb/tb_aff7seg_mux.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/aff7seg_mux.sv
// Multiplexed hex 7-segment driver: free-running slot scan, frame-aligned
// double buffer, leading-zero blanking and anti-ghosting dead cycles.
module aff7seg_mux #(
  parameter int unsigned NB_DIGITS     = 4,
  parameter int unsigned SEG_POLARITY  = 1,
  parameter int unsigned AN_POLARITY   = 0,
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned DEAD_CYCLES   = 2,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [4*NB_DIGITS-1:0]   Value,
  input  logic [NB_DIGITS-1:0]     DpIn,
  input  logic                     Load,
  input  logic                     Enable,
  output logic [6:0]               Seg,
  output logic                     Dp,
  output logic [NB_DIGITS-1:0]     An
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (NB_DIGITS > 1) ? $clog2(NB_DIGITS) : 1;
  localparam int unsigned VW = 4 * NB_DIGITS;

  localparam logic [PW-1:0]        PS_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]        DEAD     = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0]        IDX_LAST = IW'(NB_DIGITS - 1);
  localparam logic [6:0]           SEG_OFF  = (SEG_POLARITY != 0) ? 7'h00 : 7'h7F;
  localparam logic                 DP_OFF   = (SEG_POLARITY == 0);
  localparam logic [NB_DIGITS-1:0] AN_OFF   = (AN_POLARITY != 0) ? '0 : '1;

  logic [PW-1:0]        prescale;
  logic [IW-1:0]        digit_idx;
  logic [VW-1:0]        shadow_val;
  logic [NB_DIGITS-1:0] shadow_dp;
  logic                 pending;
  logic [VW-1:0]        disp_val;
  logic [NB_DIGITS-1:0] disp_dp;

  logic                 slot_end_c;
  logic                 frame_wrap_c;
  logic [NB_DIGITS-1:0] blank_c;
  logic                 all_zero_c;
  logic [3:0]           cur_nib_c;
  logic                 cur_dp_c;
  logic                 cur_blank_c;
  logic                 active_c;
  logic [6:0]           seg_act_c;
  logic [NB_DIGITS-1:0] an_act_c;
  logic [6:0]           seg_c;
  logic                 dp_c;
  logic [NB_DIGITS-1:0] an_c;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b1111110;
      4'h1:    hex7 = 7'b0110000;
      4'h2:    hex7 = 7'b1101101;
      4'h3:    hex7 = 7'b1111001;
      4'h4:    hex7 = 7'b0110011;
      4'h5:    hex7 = 7'b1011011;
      4'h6:    hex7 = 7'b1011111;
      4'h7:    hex7 = 7'b1110000;
      4'h8:    hex7 = 7'b1111111;
      4'h9:    hex7 = 7'b1111011;
      4'hA:    hex7 = 7'b1110111;
      4'hB:    hex7 = 7'b0011111;
      4'hC:    hex7 = 7'b1001110;
      4'hD:    hex7 = 7'b0111101;
      4'hE:    hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  assign slot_end_c   = (prescale == PS_LAST);
  assign frame_wrap_c = slot_end_c && (digit_idx == IDX_LAST);

  // Free-running slot prescaler and scan index
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      prescale  <= '0;
      digit_idx <= '0;
    end else begin
      prescale <= slot_end_c ? '0 : prescale + PW'(1);
      if (slot_end_c)
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);
    end
  end

  // Shadow captures on Load; display only moves at frame wrap so a frame is never torn
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
    end else begin
      if (Load) begin
        shadow_val <= Value;
        shadow_dp  <= DpIn;
      end
      if (frame_wrap_c && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      if (Load)
        pending <= 1'b1;
      else if (frame_wrap_c)
        pending <= 1'b0;
    end
  end

  // Leading-zero map: a digit blanks only if it and every higher digit are 0 with no Dp
  always_comb begin
    blank_c    = '0;
    all_zero_c = 1'b1;
    for (int i = NB_DIGITS - 1; i >= 1; i--) begin
      all_zero_c = all_zero_c && (disp_val[4*i +: 4] == 4'd0) && !disp_dp[i];
      blank_c[i] = all_zero_c && (BLANK_LEADING != 0);
    end
  end

  always_comb begin
    cur_nib_c   = '0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    an_act_c    = '0;
    for (int i = 0; i < NB_DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        cur_nib_c   = disp_val[4*i +: 4];
        cur_dp_c    = disp_dp[i];
        cur_blank_c = blank_c[i];
        an_act_c[i] = 1'b1;
      end
    end
  end

  // Next output values in active-high form, then polarity at the register input
  always_comb begin
    active_c  = Enable && (prescale >= DEAD) && !cur_blank_c;
    seg_act_c = active_c ? hex7(cur_nib_c) : 7'b0;
    seg_c     = (SEG_POLARITY != 0) ? seg_act_c : ~seg_act_c;
    dp_c      = (SEG_POLARITY != 0) ? (active_c && cur_dp_c) : !(active_c && cur_dp_c);
    an_c      = active_c ? ((AN_POLARITY != 0) ? an_act_c : ~an_act_c) : AN_OFF;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Seg <= SEG_OFF;
      Dp  <= DP_OFF;
      An  <= AN_OFF;
    end else begin
      Seg <= seg_c;
      Dp  <= dp_c;
      An  <= an_c;
    end
  end

endmodule

// File: tb/tb_aff7seg_mux.sv
// Directed bench for aff7seg_mux: 4 digits, 4-cycle slots, 1 dead cycle,
// frame-by-frame comparison against hand-computed segment tables.
module tb_aff7seg_mux;

  logic        Clk;
  logic        Rst_n;
  logic [15:0] Value;
  logic [3:0]  DpIn;
  logic        Load;
  logic        Enable;
  logic [6:0]  Seg;
  logic        Dp;
  logic [3:0]  An;

  int n_tests;
  int n_fail;

  logic [3:0] ea [4];
  logic [6:0] es [4];
  logic       ed [4];

  aff7seg_mux #(
    .NB_DIGITS(4), .SEG_POLARITY(1), .AN_POLARITY(0),
    .REFRESH_DIV(4), .DEAD_CYCLES(1), .BLANK_LEADING(1)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Value(Value), .DpIn(DpIn),
    .Load(Load), .Enable(Enable), .Seg(Seg), .Dp(Dp), .An(An)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic set_exp(input int d, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    ea[d] = an;
    es[d] = seg;
    ed[d] = dp;
  endtask

  task automatic set_blank(input int d);
    set_exp(d, 4'b1111, 7'b0000000, 1'b0);
  endtask

  // One 16-edge frame; optional loads at iterations la/lb, Enable low for iterations < en_off
  task automatic run_frame(input int fr,
                           input int la, input logic [15:0] va, input logic [3:0] da,
                           input int lb, input logic [15:0] vb, input logic [3:0] db,
                           input int en_off);
    int s;
    int p;
    logic [3:0] x_an;
    logic [6:0] x_seg;
    logic       x_dp;
    for (int i = 0; i < 16; i++) begin
      Load = 1'b0;
      if (i == la) begin Value = va; DpIn = da; Load = 1'b1; end
      if (i == lb) begin Value = vb; DpIn = db; Load = 1'b1; end
      Enable = (i >= en_off);
      step();
      s = i / 4;
      p = i % 4;
      if (i < en_off || p == 0) begin
        x_an = 4'b1111; x_seg = 7'b0; x_dp = 1'b0;
      end else begin
        x_an = ea[s]; x_seg = es[s]; x_dp = ed[s];
      end
      check($sformatf("f%0d s%0d p%0d An", fr, s, p), 32'(An), 32'(x_an));
      check($sformatf("f%0d s%0d p%0d Seg", fr, s, p), 32'(Seg), 32'(x_seg));
      check($sformatf("f%0d s%0d p%0d Dp", fr, s, p), 32'(Dp), 32'(x_dp));
    end
    Load   = 1'b0;
    Enable = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Clk = 1'b0; Rst_n = 1'b0; Enable = 1'b1; Load = 1'b0; Value = '0; DpIn = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      check("reset An", 32'(An), 32'h0000000F);
      check("reset Seg", 32'(Seg), 32'h0);
      check("reset Dp", 32'(Dp), 32'h0);
    end
    Rst_n = 1'b1;

    // Frame 0: display cleared by reset; 12AF loaded mid-frame
    set_exp(0, 4'b1110, 7'b1111110, 1'b0); set_blank(1); set_blank(2); set_blank(3);
    run_frame(0, 4, 16'h12AF, 4'b0000, -1, 16'h0, 4'b0, 0);

    // Frame 1: 12AF; 0070 loaded mid-frame
    set_exp(0, 4'b1110, 7'b1000111, 1'b0); set_exp(1, 4'b1101, 7'b1110111, 1'b0);
    set_exp(2, 4'b1011, 7'b1101101, 1'b0); set_exp(3, 4'b0111, 7'b0110000, 1'b0);
    run_frame(1, 8, 16'h0070, 4'b0000, -1, 16'h0, 4'b0, 0);

    // Frame 2: 0070 with two leading blanks; 1111 then 2222 loaded in the same frame
    set_exp(0, 4'b1110, 7'b1111110, 1'b0); set_exp(1, 4'b1101, 7'b1110000, 1'b0);
    set_blank(2); set_blank(3);
    run_frame(2, 2, 16'h1111, 4'b0000, 9, 16'h2222, 4'b0000, 0);

    // Frame 3: 2222 only; 3456 mid-frame, then 0789 exactly on the wrap edge
    for (int d = 0; d < 4; d++) set_exp(d, ~(4'b0001 << d), 7'b1101101, 1'b0);
    run_frame(3, 3, 16'h3456, 4'b0000, 15, 16'h0789, 4'b0001, 0);

    // Frame 4: pre-edge shadow 3456
    set_exp(0, 4'b1110, 7'b1011111, 1'b0); set_exp(1, 4'b1101, 7'b1011011, 1'b0);
    set_exp(2, 4'b1011, 7'b0110011, 1'b0); set_exp(3, 4'b0111, 7'b1111001, 1'b0);
    run_frame(4, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0, 0);

    // Frame 5: 0789 with Dp on digit 0
    set_exp(0, 4'b1110, 7'b1111011, 1'b1); set_exp(1, 4'b1101, 7'b1111111, 1'b0);
    set_exp(2, 4'b1011, 7'b1110000, 1'b0); set_blank(3);
    run_frame(5, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0, 0);

    // Reset for one cycle in the middle of slot 0
    step();
    step();
    Rst_n = 1'b0;
    step();
    check("midrst An", 32'(An), 32'h0000000F);
    check("midrst Seg", 32'(Seg), 32'h0);
    check("midrst Dp", 32'(Dp), 32'h0);
    Rst_n = 1'b1;

    // Restarted frame: display back to 0, 12AF reloaded
    set_exp(0, 4'b1110, 7'b1111110, 1'b0); set_blank(1); set_blank(2); set_blank(3);
    run_frame(6, 3, 16'h12AF, 4'b0000, -1, 16'h0, 4'b0, 0);

    // Enable low for three slots; scan resumes on slot 3 from the running counters
    set_exp(0, 4'b1110, 7'b1000111, 1'b0); set_exp(1, 4'b1101, 7'b1110111, 1'b0);
    set_exp(2, 4'b1011, 7'b1101101, 1'b0); set_exp(3, 4'b0111, 7'b0110000, 1'b0);
    run_frame(7, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0, 12);

    run_frame(8, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
